wbu_arb: RTL and testbench

WBU_ARB -- requirements
Module: wbu_arb

---
 rtl/wbu_arb.sv | 193 +++++++++++++++++++
 tb/tb_wbu_arb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wbu_arb.sv
// wbu_arb -- writeback arbiter between the ALU result path and the load unit.
//
// The single register-file write port is shared by three sources: buffered
// ALU results, load results from the LSU, and an ALU result bypassing an
// empty buffer. ALU results the port cannot take immediately are queued in
// a small FIFO and retire in acceptance order. A full buffer takes priority
// over loads so that the ALU can never be stalled indefinitely.
//
// Optional feature (macro WBU_FWD_EN): a combinational forwarding lookup
// that returns the youngest pending write to fwd_raddr_i. It searches the
// ALU input accepted this cycle, then the FIFO from tail to head, then the
// registered output stage. Without the macro, fwd_hit_o/fwd_data_o are tied
// to 0 and the ports are kept.
//
// Parameters:
//   FIFO_DEPTH       ALU-result buffer entries (power of two, 2..16)
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous active-high reset
//   alu_reg_we_i     ALU result valid this cycle
//   alu_reg_waddr_i  ALU destination register (x0 accepted and discarded)
//   alu_reg_wdata_i  ALU result
//   alu_stall_o      buffer full, ALU input not accepted
//   lsu_valid_i      load result valid
//   lsu_reg_waddr_i  load destination register (x0 acked, not written)
//   lsu_reg_wdata_i  load data
//   lsu_ready_o      load result accepted this cycle
//   fwd_raddr_i      forwarding lookup register
//   fwd_hit_o        a pending write to fwd_raddr_i exists
//   fwd_data_o       data of the youngest pending write to fwd_raddr_i
//   reg_we_o         registered regfile write enable
//   reg_waddr_o      registered regfile write address
//   reg_wdata_o      registered regfile write data
module wbu_arb #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_reg_we_i,
   input  logic [4:0]  alu_reg_waddr_i,
   input  logic [31:0] alu_reg_wdata_i,
   output logic        alu_stall_o,
   input  logic        lsu_valid_i,
   input  logic [4:0]  lsu_reg_waddr_i,
   input  logic [31:0] lsu_reg_wdata_i,
   output logic        lsu_ready_o,
   input  logic [4:0]  fwd_raddr_i,
   output logic        fwd_hit_o,
   output logic [31:0] fwd_data_o,
   output logic        reg_we_o,
   output logic [4:0]  reg_waddr_o,
   output logic [31:0] reg_wdata_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

   logic [4:0]       addr_mem [FIFO_DEPTH];
   logic [31:0]      data_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [PTR_W:0]   count_reg, count_next;

   logic        full;
   logic        alu_acc;     // handshake completed on the ALU side
   logic        alu_keep;    // accepted and carries a real destination
   logic        deq, enq, bypass;
   logic        win_we;
   logic [4:0]  win_addr;
   logic [31:0] win_data;

   assign full        = (count_reg == FULL_CNT);
   assign alu_stall_o = full;
   // Qualified with rst so the handshake reads as idle while held in reset.
   assign lsu_ready_o = lsu_valid_i & ~full & ~rst;
   assign alu_acc     = alu_reg_we_i & ~full;
   assign alu_keep    = alu_acc & (alu_reg_waddr_i != 5'd0);

   // Write-port arbitration. Entries in the FIFO never have address 0,
   // since x0 results are dropped before enqueue.
   always_comb begin
      win_we   = 1'b0;
      win_addr = 5'd0;
      win_data = 32'd0;
      deq      = 1'b0;
      bypass   = 1'b0;
      if (full) begin
         deq      = 1'b1;
         win_we   = 1'b1;
         win_addr = addr_mem[rd_ptr_reg];
         win_data = data_mem[rd_ptr_reg];
      end else if (lsu_valid_i) begin
         // A load to x0 still consumes the port slot but writes nothing.
         if (lsu_reg_waddr_i != 5'd0) begin
            win_we   = 1'b1;
            win_addr = lsu_reg_waddr_i;
            win_data = lsu_reg_wdata_i;
         end
      end else if (count_reg != '0) begin
         deq      = 1'b1;
         win_we   = 1'b1;
         win_addr = addr_mem[rd_ptr_reg];
         win_data = data_mem[rd_ptr_reg];
      end else if (alu_keep) begin
         bypass   = 1'b1;
         win_we   = 1'b1;
         win_addr = alu_reg_waddr_i;
         win_data = alu_reg_wdata_i;
      end
   end

   assign enq = alu_keep & ~bypass;

   // Enqueue while full cannot happen (ALU stalled), and a dequeue only
   // occurs with count > 0, so count stays within 0..FIFO_DEPTH.
   always_comb begin
      count_next = count_reg;
      case ({enq, deq})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         reg_we_o    <= 1'b0;
         reg_waddr_o <= 5'd0;
         reg_wdata_o <= 32'd0;
      end else begin
         if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg   <= count_next;
         reg_we_o    <= win_we;
         reg_waddr_o <= win_addr;
         reg_wdata_o <= win_data;
      end
   end

   // Storage carries no reset: stale entries are unreachable once count is 0.
   always_ff @(posedge clk) begin
      if (enq) begin
         addr_mem[wr_ptr_reg] <= alu_reg_waddr_i;
         data_mem[wr_ptr_reg] <= alu_reg_wdata_i;
      end
   end

`ifdef WBU_FWD_EN
   logic [PTR_W-1:0] ent_idx   [FIFO_DEPTH];
   logic             ent_match [FIFO_DEPTH];

   // Slot gi holds the gi-th oldest pending entry when gi < count.
   generate
      for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_ent
         assign ent_idx[gi]   = rd_ptr_reg + PTR_W'(gi);
         assign ent_match[gi] = (count_reg > (PTR_W+1)'(gi)) &&
                                (addr_mem[ent_idx[gi]] == fwd_raddr_i);
      end
   endgenerate

   // Oldest source first so that each younger match overrides.
   always_comb begin
      fwd_hit_o  = 1'b0;
      fwd_data_o = 32'd0;
      if (reg_we_o && (reg_waddr_o == fwd_raddr_i)) begin
         fwd_hit_o  = 1'b1;
         fwd_data_o = reg_wdata_o;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (ent_match[i]) begin
            fwd_hit_o  = 1'b1;
            fwd_data_o = data_mem[ent_idx[i]];
         end
      end
      if (alu_keep && (alu_reg_waddr_i == fwd_raddr_i)) begin
         fwd_hit_o  = 1'b1;
         fwd_data_o = alu_reg_wdata_i;
      end
      if (rst || (fwd_raddr_i == 5'd0)) begin
         fwd_hit_o  = 1'b0;
         fwd_data_o = 32'd0;
      end
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^fwd_raddr_i;
   assign fwd_hit_o  = 1'b0;
   assign fwd_data_o = 32'd0;
`endif

endmodule

// File: tb/tb_wbu_arb.sv
module tb_wbu_arb;

   localparam int D = 4;
`ifdef WBU_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_reg_we_i;
   logic [4:0]  alu_reg_waddr_i;
   logic [31:0] alu_reg_wdata_i;
   logic        alu_stall_o;
   logic        lsu_valid_i;
   logic [4:0]  lsu_reg_waddr_i;
   logic [31:0] lsu_reg_wdata_i;
   logic        lsu_ready_o;
   logic [4:0]  fwd_raddr_i;
   logic        fwd_hit_o;
   logic [31:0] fwd_data_o;
   logic        reg_we_o;
   logic [4:0]  reg_waddr_o;
   logic [31:0] reg_wdata_o;

   wbu_arb #(.FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .alu_reg_we_i(alu_reg_we_i), .alu_reg_waddr_i(alu_reg_waddr_i),
      .alu_reg_wdata_i(alu_reg_wdata_i), .alu_stall_o(alu_stall_o),
      .lsu_valid_i(lsu_valid_i), .lsu_reg_waddr_i(lsu_reg_waddr_i),
      .lsu_reg_wdata_i(lsu_reg_wdata_i), .lsu_ready_o(lsu_ready_o),
      .fwd_raddr_i(fwd_raddr_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
      .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;
   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   wr_t  sb[$];       // expected write-port values, one per clock
   ent_t fifo_m[$];   // reference contents of the ALU buffer
   wr_t  out_m;       // reference registered output stage
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus. Entered and left 1 time unit after a rising edge.
   task automatic step(input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic [4:0] fr, output bit a_ok, output bit l_ok);
      wr_t         win, got;
      bit          full, accv, used;
      logic        eh;
      logic [31:0] ed;
      alu_reg_we_i = aw; alu_reg_waddr_i = aa; alu_reg_wdata_i = ad;
      lsu_valid_i = lv;  lsu_reg_waddr_i = la; lsu_reg_wdata_i = ld;
      fwd_raddr_i = fr;
      #1;
      full = (fifo_m.size() == D);
      accv = aw && !full && (aa != 5'd0);
      eh = 1'b0; ed = 32'd0;
      if (out_m.we && out_m.a == fr) begin eh = 1'b1; ed = out_m.d; end
      foreach (fifo_m[i]) if (fifo_m[i].a == fr) begin eh = 1'b1; ed = fifo_m[i].d; end
      if (accv && aa == fr) begin eh = 1'b1; ed = ad; end
      if (!FWD || fr == 5'd0) begin eh = 1'b0; ed = 32'd0; end
      chk("alu_stall", alu_stall_o, full);
      chk("lsu_ready", lsu_ready_o, lv && !full);
      chk("fwd_hit", fwd_hit_o, eh);
      chk("fwd_data", fwd_data_o, ed);
      a_ok = aw && !full;
      l_ok = lv && !full;
      win = '0; used = 1'b0;
      if (full) begin
         win.we = 1'b1; win.a = fifo_m[0].a; win.d = fifo_m[0].d;
         void'(fifo_m.pop_front());
      end else if (lv) begin
         if (la != 5'd0) begin win.we = 1'b1; win.a = la; win.d = ld; end
      end else if (fifo_m.size() > 0) begin
         win.we = 1'b1; win.a = fifo_m[0].a; win.d = fifo_m[0].d;
         void'(fifo_m.pop_front());
      end else if (accv) begin
         win.we = 1'b1; win.a = aa; win.d = ad; used = 1'b1;
      end
      if (accv && !used) fifo_m.push_back('{a: aa, d: ad});
      sb.push_back(win);
      @(posedge clk); #1;
      got = sb.pop_front();
      out_m = got;
      chk("reg_we", reg_we_o, got.we);
      chk("reg_waddr", reg_waddr_o, got.a);
      chk("reg_wdata", reg_wdata_o, got.d);
      $display("step alu=%b/x%0d/%h lsu=%b/x%0d/%h -> we=%b x%0d=%h fwd=%b/%h",
               aw, aa, ad, lv, la, ld, reg_we_o, reg_waddr_o, reg_wdata_o,
               fwd_hit_o, fwd_data_o);
   endtask

   task automatic idle(input logic [4:0] fr);
      bit a, l;
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, fr, a, l);
   endtask

   initial begin
      bit a_ok, l_ok, saw_stall;
      int ai, li;
      rst = 1'b1;
      alu_reg_we_i = 1'b0; alu_reg_waddr_i = 5'd0; alu_reg_wdata_i = 32'd0;
      lsu_valid_i = 1'b1; lsu_reg_waddr_i = 5'd2; lsu_reg_wdata_i = 32'h5;
      fwd_raddr_i = 5'd0;
      out_m = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_reg_we", reg_we_o, 1'b0);
      chk("rst_reg_waddr", reg_waddr_o, 5'd0);
      chk("rst_reg_wdata", reg_wdata_o, 32'd0);
      chk("rst_stall", alu_stall_o, 1'b0);
      chk("rst_lsu_ready", lsu_ready_o, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      lsu_valid_i = 1'b0;
      @(posedge clk); #1;

      // Empty buffer: ALU result bypasses with latency 1, nothing queued.
      step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd5, a_ok, l_ok);
      idle(5'd5);
      idle(5'd0);

      // LSU wins over a simultaneous ALU result, which follows next cycle.
      step(1'b1, 5'd4, 32'hBB, 1'b1, 5'd3, 32'hAA, 5'd4, a_ok, l_ok);
      idle(5'd4);
      idle(5'd4);

      // Sustained load stream with ALU issuing every cycle: buffer fills.
      ai = 0; li = 0; saw_stall = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step(1'b1, 5'(8 + ai), 32'hA0 + 32'(ai), 1'b1, 5'(16 + li), 32'hC0 + 32'(li),
              5'(8 + ai), a_ok, l_ok);
         if (alu_stall_o) saw_stall = 1'b1;
         if (a_ok) ai++;
         if (l_ok) li++;
      end
      for (int c = 0; c < 6; c++) idle(5'd8);
      chk("saw_full", 32'(ai), 32'd5);

      // Writes to x0 from either source are acknowledged but never written.
      step(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 5'd0, a_ok, l_ok);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 5'd0, a_ok, l_ok);
      idle(5'd0);

      // Two queued writes to x7: forwarding returns the younger one.
      step(1'b1, 5'd7, 32'h1, 1'b1, 5'd9, 32'h99, 5'd7, a_ok, l_ok);
      step(1'b1, 5'd7, 32'h2, 1'b1, 5'd10, 32'h9A, 5'd7, a_ok, l_ok);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'h9B, 5'd7, a_ok, l_ok);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h9C, 5'd0, a_ok, l_ok);
      idle(5'd7);
      idle(5'd7);
      idle(5'd7);

      // Reset asserted mid-cycle with three entries pending.
      for (int c = 0; c < 3; c++)
         step(1'b1, 5'(13 + c), 32'hD0 + 32'(c), 1'b1, 5'(20 + c), 32'hE0 + 32'(c),
              5'd13, a_ok, l_ok);
      alu_reg_we_i = 1'b1; alu_reg_waddr_i = 5'd14;
      lsu_valid_i = 1'b1;  lsu_reg_waddr_i = 5'd25;
      fwd_raddr_i = 5'd14;
      #2 rst = 1'b1;
      #1;
      chk("arst_reg_we", reg_we_o, 1'b0);
      chk("arst_reg_waddr", reg_waddr_o, 5'd0);
      chk("arst_reg_wdata", reg_wdata_o, 32'd0);
      chk("arst_stall", alu_stall_o, 1'b0);
      chk("arst_lsu_ready", lsu_ready_o, 1'b0);
      chk("arst_fwd_hit", fwd_hit_o, 1'b0);
      fifo_m.delete();
      sb.delete();
      out_m = '0;
      @(posedge clk); #1;
      chk("arst_hold_we", reg_we_o, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      alu_reg_we_i = 1'b0; lsu_valid_i = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_we", reg_we_o, 1'b0);
      idle(5'd14);
      idle(5'd13);
      idle(5'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
